// File: rtl/potatov_pkg.sv
// Shared integer-register definitions for the potatov core: default widths
// and the zero-register check used by the register bank and its scoreboard.
package potatov_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;
  localparam int ADDR_MAX_W   = 8;   // widest register index supported (NREGS <= 256)

  function automatic logic is_zero_reg(input logic [ADDR_MAX_W-1:0] addr);
    return addr == '0;
  endfunction
endpackage

// File: rtl/register_scoreboard.sv
// Busy scoreboard: one pending bit per register, set by claim, cleared by
// writeback or flush, with a registered popcount of the busy vector.
module register_scoreboard
  import potatov_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                claim_valid,
  input  logic [AW-1:0]       claim_addr,
  input  logic                clear_valid,
  input  logic [AW-1:0]       clear_addr,
  input  logic                flush,
  input  logic [NREAD*AW-1:0] lookup_addr,
  output logic [NREAD-1:0]    lookup_busy,
  output logic [AW:0]         count
);
  logic [NREGS-1:0] busy, busy_next;
  logic [AW:0]      count_next;

  // Order matters: flush, then writeback clear, then claim, so the newest
  // owner of a register wins every same-cycle collision.
  always_comb begin
    busy_next = flush ? '0 : busy;
    if (clear_valid) busy_next[clear_addr] = 1'b0;
    if (claim_valid && !is_zero_reg(ADDR_MAX_W'(claim_addr)))
      busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
    count_next = '0;
    for (int i = 1; i < NREGS; i++)
      count_next = count_next + {{AW{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_lookup
    assign lookup_busy[i] = busy[lookup_addr[i*AW +: AW]];
  end
endmodule

// File: rtl/register_bank.sv
// Integer register file: NREAD combinational read ports, one write port,
// optional write-to-read bypass, and a busy scoreboard for RAW hazards.
module register_bank
  import potatov_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_valid,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_valid,
  input  logic [AW-1:0]         claim_addr,
  input  logic                  flush,
  output logic [AW:0]           busy_count
);
  logic [XLEN-1:0]  mem [1:NREGS-1];
  logic [NREAD-1:0] sb_busy;
  logic             wr_en;

  assign wr_en = wr_valid && !is_zero_reg(ADDR_MAX_W'(wr_addr));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  register_scoreboard #(.NREGS(NREGS), .NREAD(NREAD)) u_sb (
    .clock       (clock),
    .reset       (reset),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .clear_valid (wr_valid),
    .clear_addr  (wr_addr),
    .flush       (flush),
    .lookup_addr (rd_addr),
    .lookup_busy (sb_busy),
    .count       (busy_count)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    logic            fwd;

    assign a   = rd_addr[i*AW +: AW];
    assign fwd = (BYPASS != 0) && wr_valid && (wr_addr == a);

    // A forwarded write retires the hazard, so the reader sees it as not busy.
    always_comb begin
      d = '0;
      b = 1'b0;
      if (!is_zero_reg(ADDR_MAX_W'(a))) begin
        if (fwd) begin
          d = wr_data;
        end else begin
          d = mem[a];
          b = sb_busy[i];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_busy[i]              = b;
  end
endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: bypassing and non-bypassing instances share one
// stimulus stream and are compared against an array-based reference model.
module tb_register_bank;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NREAD-1:0]      rd_busy_b, rd_busy_n;
  logic                  wr_valid;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  claim_valid;
  logic [AW-1:0]         claim_addr;
  logic                  flush;
  logic [AW:0]           busy_count_b, busy_count_n;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  register_bank #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .flush(flush),
    .busy_count(busy_count_b));

  register_bank #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_n (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .flush(flush),
    .busy_count(busy_count_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < NREGS; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_valid    = 1'b0;
    claim_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] port_data(input logic [NREAD*XLEN-1:0] v, input int p);
    return v[p*XLEN +: XLEN];
  endfunction

  // Expected read results follow directly from the read rules: x0 is zero,
  // a same-cycle write wins only on the bypassing instance.
  task automatic check_outputs();
    for (int p = 0; p < NREAD; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] dn, db;
      logic            bn, bb, fwd;
      a   = rd_addr[p*AW +: AW];
      dn  = (a == 0) ? '0 : m_reg[a];
      bn  = (a == 0) ? 1'b0 : m_busy[a];
      fwd = wr_valid && (wr_addr == a) && (a != 0);
      db  = fwd ? wr_data : dn;
      bb  = fwd ? 1'b0 : bn;
      chk($sformatf("rd_data_b[%0d] x%0d", p, a), 64'(port_data(rd_data_b, p)), 64'(db));
      chk($sformatf("rd_busy_b[%0d] x%0d", p, a), 64'(rd_busy_b[p]), 64'(bb));
      chk($sformatf("rd_data_n[%0d] x%0d", p, a), 64'(port_data(rd_data_n, p)), 64'(dn));
      chk($sformatf("rd_busy_n[%0d] x%0d", p, a), 64'(rd_busy_n[p]), 64'(bn));
    end
    chk("busy_count_b", 64'(busy_count_b), 64'(m_count()));
    chk("busy_count_n", 64'(busy_count_n), 64'(m_count()));
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, applies the edge.
  task automatic step();
    #4;
    check_outputs();
    if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    if (wr_valid && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
    model_clear();

    // Reset state across every address.
    #2;
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(NREGS - 1 - a));
      #0.1;
      check_outputs();
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Asynchronous reset mid-stream.
    wr_valid = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
    step();
    idle();
    #1;
    chk("x5_written", 64'(port_data(rd_data_n, 0)), 64'h0DEADBEEF);
    reset = 1'b1;
    #1;
    chk("x5_async_reset_b", 64'(port_data(rd_data_b, 0)), 64'h0);
    chk("x5_async_reset_n", 64'(port_data(rd_data_n, 0)), 64'h0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // x0 ignores writes and claims.
    wr_valid = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; set_rd(0, 0); set_rd(1, 0);
    step();
    idle(); claim_valid = 1'b1; claim_addr = 0;
    step();
    idle();
    #1;
    chk("x0_read", 64'(port_data(rd_data_b, 0)), 64'h0);
    chk("x0_claim_count", 64'(busy_count_b), 64'h0);

    // Same-cycle bypass versus old value.
    wr_valid = 1'b1; wr_addr = 7; wr_data = 32'h12345678; set_rd(0, 7);
    #1;
    chk("bypass_b_same", 64'(port_data(rd_data_b, 0)), 64'h12345678);
    chk("bypass_n_same", 64'(port_data(rd_data_n, 0)), 64'h0);
    step();
    idle();
    #1;
    chk("bypass_n_next", 64'(port_data(rd_data_n, 0)), 64'h12345678);

    // Claim then writeback of x3.
    claim_valid = 1'b1; claim_addr = 3; set_rd(0, 3);
    step();
    idle();
    #1;
    chk("x3_busy", 64'(rd_busy_n[0]), 64'h1);
    chk("x3_count", 64'(busy_count_n), 64'h1);
    wr_valid = 1'b1; wr_addr = 3; wr_data = 32'hA5;
    step();
    idle();
    #1;
    chk("x3_clear_busy", 64'(rd_busy_n[0]), 64'h0);
    chk("x3_data", 64'(port_data(rd_data_n, 0)), 64'hA5);
    chk("x3_clear_count", 64'(busy_count_n), 64'h0);

    // Claim and write same register, same cycle.
    claim_valid = 1'b1; claim_addr = 4; wr_valid = 1'b1; wr_addr = 4; wr_data = 32'h55;
    set_rd(1, 4);
    step();
    idle();
    #1;
    chk("x4_data", 64'(port_data(rd_data_n, 1)), 64'h55);
    chk("x4_busy", 64'(rd_busy_n[1]), 64'h1);
    chk("x4_count", 64'(busy_count_n), 64'h1);
    wr_valid = 1'b1; wr_addr = 4; wr_data = 32'h55;
    step();

    // Three claims, then flush with a claim of x2.
    idle(); claim_valid = 1'b1; claim_addr = 1; step();
    claim_addr = 2; step();
    claim_addr = 9; step();
    idle();
    #1;
    chk("three_claims", 64'(busy_count_b), 64'h3);
    flush = 1'b1; claim_valid = 1'b1; claim_addr = 2; set_rd(0, 2); set_rd(1, 1);
    step();
    idle();
    #1;
    chk("flush_count", 64'(busy_count_b), 64'h1);
    chk("flush_x2_busy", 64'(rd_busy_b[0]), 64'h1);
    chk("flush_x1_idle", 64'(rd_busy_b[1]), 64'h0);
    set_rd(0, 3); set_rd(1, 7);
    #1;
    chk("flush_x3_kept", 64'(port_data(rd_data_b, 0)), 64'hA5);
    chk("flush_x7_kept", 64'(port_data(rd_data_b, 1)), 64'h12345678);
    step();

    // Random traffic against the model.
    repeat (500) begin
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_addr     = AW'($urandom_range(0, NREGS - 1));
      wr_data     = $urandom;
      claim_valid = ($urandom_range(0, 1) == 1);
      claim_addr  = ($urandom_range(0, 5) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      flush       = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NREAD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1)));
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_bank.md
# register_bank

- Parametrised successor of the core's integer register file: N combinational read ports, one write port, optional same-cycle write-to-read bypass.
- Adds a busy scoreboard so the issue stage can detect read-after-write hazards against in-flight writebacks.
- Sits between decode/issue (read, claim) and writeback (write); register 0 is hardwired to zero and never busy.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see the old value

Ports:
- clock, input, 1, single clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-high; clears all registers and busy bits
- rd_addr, input, NREAD*AW, read addresses; port i occupies bits [i*AW +: AW]
- rd_data, output, NREAD*XLEN, read data per port; combinational
- rd_busy, output, NREAD, per-port hazard flag; combinational
- wr_valid, input, 1, writeback strobe
- wr_addr, input, AW, writeback address
- wr_data, input, XLEN, writeback data
- claim_valid, input, 1, issue marks the destination register pending
- claim_addr, input, AW, destination register being claimed
- flush, input, 1, clears every busy bit (pipeline squash)
- busy_count, output, AW+1, number of registers currently busy; registered

## Operation
- Storage: NREGS-1 registers of XLEN bits, indices 1..NREGS-1; index 0 has no storage.
- Read, port i:
  - rd_addr==0 → rd_data=0, rd_busy=0.
  - BYPASS=1, wr_valid, and wr_addr==rd_addr≠0 → rd_data=wr_data, rd_busy=0.
  - Otherwise → rd_data = stored value; rd_busy = busy[rd_addr].
- Write: wr_valid with wr_addr≠0 stores wr_data at the edge and clears busy[wr_addr]. Writes to 0 are ignored.
- Claim: claim_valid with claim_addr≠0 sets busy[claim_addr] at the edge. Claims of 0 are ignored.
- Simultaneous events on the same address:
  - Claim and write → data is stored and busy ends up set (the newer instruction owns the register).
  - Flush and write → data is stored and busy is cleared.
  - Flush and claim → every busy bit is cleared except busy[claim_addr], which is set.
  - Flush has no effect on register contents.
- busy_count: popcount of the next busy vector, registered at the same edge as the busy bits, so it always matches the busy vector.
- Claiming an already-busy register keeps it busy; busy_count does not change.

## Timing
- Reset values:
  - All registers = 0, all busy = 0, busy_count = 0.
  - rd_data = 0 and rd_busy = 0 for every port; both are combinational from cleared state.
- Reset asserted mid-operation takes effect immediately, with no clock required. Writes and claims in the cycle reset deasserts are taken at the next edge.
- Read latency is 0 cycles (combinational).
- Write latency:
  - Visible to reads in the cycle after wr_valid.
  - With BYPASS=1, also visible in the same cycle.
- Claim latency: rd_busy rises in the cycle after claim_valid. There is no same-cycle claim forwarding; issue logic handles back-to-back claims.
- No handshake backpressure: every write, claim and flush is accepted unconditionally.

## Structure
- Shared package potatov_pkg: XLEN default, REG_AW, and a function for the zero-register check.
- Sub-module register_scoreboard: busy vector, claim/write/flush priority, and busy_count popcount. Its ports are claim, clear (from write), flush, a lookup address vector, and the count.
- register_bank holds the data array, read muxes and bypass, and instantiates register_scoreboard.

## Test plan
- Reset, then read all addresses → rd_data=0, rd_busy=0, busy_count=0. Assert reset mid-stream after writing x5=0xDEADBEEF → x5 reads 0 with no clock edge.
- Write x0=0xFFFFFFFF, then read x0 → 0. Claim x0 → busy_count stays 0.
- BYPASS=1: write x7=0x12345678 with rd_addr[0]=7 in the same cycle → rd_data[0]=0x12345678 that cycle. BYPASS=0: same stimulus → old value 0, then 0x12345678 next cycle.
- Claim x3 → next cycle rd_busy=1 and busy_count=1. Write x3=0xA5 → next cycle rd_busy=0, data 0xA5, busy_count=0.
- Same cycle claim x4 and write x4=0x55 → x4=0x55, busy=1, busy_count=1.
- Claim x1, x2, x9 on successive cycles → busy_count=3. Then flush together with claim x2 → busy_count=1, only x2 busy, register contents unchanged.
